// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin arbiter sharing one i2c_master between NREQ requesters
//
// Purpose: accepts per-requester transaction requests (level REQ plus RW/ADDR/MOSI
// fields), grants one at a time in round-robin order, drives the i2c_master
// enable/busy handshake and returns the read byte with a one-cycle DONE pulse.
// A launch that never sees M_BUSY within TIMEOUT cycles is aborted with ERR.
//
// Ports:
//   SYS_CLOCK          system clock, rising edge
//   RST                synchronous active-high reset
//   REQ/REQ_RW         per-requester request level and direction (1=read)
//   REQ_ADDR/REQ_MOSI  packed per-requester 7-bit address / 8-bit write byte
//   ACK/DONE/ERR       one-hot single-cycle pulses (accepted / complete / aborted)
//   RDATA              byte captured at completion, held until the next DONE
//   GRANT_ID           index of the current or last granted requester
//   M_ENABLE/M_RW/M_ADDR/M_MOSI  to the i2c_master
//   M_MISO/M_BUSY      from the i2c_master

module i2c_txn_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                SYS_CLOCK,
  input  logic                RST,
  input  logic [NREQ-1:0]     REQ,
  input  logic [NREQ-1:0]     REQ_RW,
  input  logic [7*NREQ-1:0]   REQ_ADDR,
  input  logic [8*NREQ-1:0]   REQ_MOSI,
  output logic [NREQ-1:0]     ACK,
  output logic [NREQ-1:0]     DONE,
  output logic [NREQ-1:0]     ERR,
  output logic [7:0]          RDATA,
  output logic [IDW-1:0]      GRANT_ID,
  output logic                M_ENABLE,
  output logic                M_RW,
  output logic [6:0]          M_ADDR,
  output logic [7:0]          M_MOSI,
  input  logic [7:0]          M_MISO,
  input  logic                M_BUSY
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW:0]   LAST_W  = (IDW+1)'(NREQ-1);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ-1);
  localparam logic [TW-1:0]  TMAX    = TW'(TIMEOUT-1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_FINISH} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            m_enable_q, m_enable_d;
  logic            m_rw_q, m_rw_d;
  logic [6:0]      m_addr_q, m_addr_d;
  logic [7:0]      m_mosi_q, m_mosi_d;
  logic [TW-1:0]   timer_q, timer_d;

  // Winner search: rotate REQ so bit 0 is the pointer position, take the lowest
  // set bit, then map back to an absolute index with an explicit wrap compare
  // so non-power-of-2 NREQ works.
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              win_found;
  logic [IDW:0]      win_sum;
  logic [IDW-1:0]    win_id;
  logic              sel_rw;
  logic [6:0]        sel_addr;
  logic [7:0]        sel_mosi;

  always_comb begin
    req_dbl   = {REQ, REQ} >> ptr_q;
    req_rot   = req_dbl[NREQ-1:0];
    win_found = |req_rot;
    win_sum   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_sum = {1'b0, ptr_q} + (IDW+1)'(k);
      end
    end
    if (win_sum > LAST_W) begin
      win_sum = win_sum - NREQ_W;
    end
    win_id = win_sum[IDW-1:0];
  end

  always_comb begin
    sel_rw   = 1'b0;
    sel_addr = '0;
    sel_mosi = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_id == IDW'(k)) begin
        sel_rw   = REQ_RW[k];
        sel_addr = REQ_ADDR[7*k +: 7];
        sel_mosi = REQ_MOSI[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    ack_d      = '0;
    done_d     = '0;
    err_d      = '0;
    rdata_d    = rdata_q;
    m_enable_d = m_enable_q;
    m_rw_d     = m_rw_q;
    m_addr_d   = m_addr_q;
    m_mosi_d   = m_mosi_q;
    timer_d    = timer_q;

    case (state_q)
      S_IDLE: begin
        // Holding off while M_BUSY is high also covers a reset that landed
        // in the middle of a transfer the master is still finishing.
        if (win_found && !M_BUSY) begin
          m_rw_d     = sel_rw;
          m_addr_d   = sel_addr;
          m_mosi_d   = sel_mosi;
          grant_d    = win_id;
          ack_d      = NREQ'(1) << win_id;
          m_enable_d = 1'b1;
          timer_d    = '0;
          ptr_d      = (win_id == LAST_ID) ? '0 : win_id + IDW'(1);
          state_d    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (M_BUSY) begin
          m_enable_d = 1'b0;
          state_d    = S_RUN;
        end else if (timer_q == TMAX) begin
          m_enable_d = 1'b0;
          err_d      = NREQ'(1) << grant_q;
          state_d    = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RUN: begin
        if (!M_BUSY) begin
          rdata_d = M_MISO;
          done_d  = NREQ'(1) << grant_q;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge SYS_CLOCK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
      m_enable_q <= 1'b0;
      m_rw_q     <= 1'b0;
      m_addr_q   <= '0;
      m_mosi_q   <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      m_enable_q <= m_enable_d;
      m_rw_q     <= m_rw_d;
      m_addr_q   <= m_addr_d;
      m_mosi_q   <= m_mosi_d;
      timer_q    <= timer_d;
    end
  end

  assign ACK      = ack_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign RDATA    = rdata_q;
  assign GRANT_ID = grant_q;
  assign M_ENABLE = m_enable_q;
  assign M_RW     = m_rw_q;
  assign M_ADDR   = m_addr_q;
  assign M_MOSI   = m_mosi_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - directed self-checking bench for i2c_txn_arbiter

module tb_i2c_txn_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  logic              SYS_CLOCK = 1'b0;
  logic              RST       = 1'b1;
  logic [NREQ-1:0]   REQ       = '0;
  logic [NREQ-1:0]   REQ_RW    = '0;
  logic [7*NREQ-1:0] REQ_ADDR  = '0;
  logic [8*NREQ-1:0] REQ_MOSI  = '0;
  logic [NREQ-1:0]   ACK, DONE, ERR;
  logic [7:0]        RDATA;
  logic [1:0]        GRANT_ID;
  logic              M_ENABLE, M_RW;
  logic [6:0]        M_ADDR;
  logic [7:0]        M_MOSI;
  logic [7:0]        M_MISO    = '0;
  logic              M_BUSY    = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  i2c_txn_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .SYS_CLOCK(SYS_CLOCK), .RST(RST),
    .REQ(REQ), .REQ_RW(REQ_RW), .REQ_ADDR(REQ_ADDR), .REQ_MOSI(REQ_MOSI),
    .ACK(ACK), .DONE(DONE), .ERR(ERR), .RDATA(RDATA), .GRANT_ID(GRANT_ID),
    .M_ENABLE(M_ENABLE), .M_RW(M_RW), .M_ADDR(M_ADDR), .M_MOSI(M_MOSI),
    .M_MISO(M_MISO), .M_BUSY(M_BUSY)
  );

  always #5 SYS_CLOCK = ~SYS_CLOCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge SYS_CLOCK);
    #1;
  endtask

  // One full transaction starting from IDLE with the request already raised.
  task automatic serve(input int id, input logic [7:0] miso, input logic [6:0] addr);
    step();
    check("serve_ack", 32'(ACK), 32'(1 << id));
    check("serve_gid", 32'(GRANT_ID), 32'(id));
    check("serve_addr", 32'(M_ADDR), 32'(addr));
    check("serve_en", 32'(M_ENABLE), 32'd1);
    M_BUSY = 1'b1;
    step();
    check("serve_en_off", 32'(M_ENABLE), 32'd0);
    M_BUSY = 1'b0;
    M_MISO = miso;
    step();
    check("serve_done", 32'(DONE), 32'(1 << id));
    check("serve_rdata", 32'(RDATA), 32'(miso));
    step();
    check("serve_done_clr", 32'(DONE), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [NREQ-1:0] acc;

    // Reset state
    step();
    step();
    check("rst_ack", 32'(ACK), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_en", 32'(M_ENABLE), 32'd0);
    check("rst_rdata", 32'(RDATA), 32'd0);
    check("rst_gid", 32'(GRANT_ID), 32'd0);
    check("rst_addr", 32'(M_ADDR), 32'd0);
    RST = 1'b0;
    step();

    // Single write from requester 0
    REQ_ADDR[6:0] = 7'h48;
    REQ_MOSI[7:0] = 8'hA5;
    REQ_RW[0]     = 1'b0;
    REQ           = 4'b0001;
    step();
    check("wr_ack", 32'(ACK), 32'b0001);
    check("wr_addr", 32'(M_ADDR), 32'h48);
    check("wr_mosi", 32'(M_MOSI), 32'hA5);
    check("wr_rw", 32'(M_RW), 32'd0);
    check("wr_en", 32'(M_ENABLE), 32'd1);
    REQ = '0;
    step();
    check("wr_en_hold", 32'(M_ENABLE), 32'd1);
    check("wr_ack_pulse", 32'(ACK), 32'd0);
    M_BUSY = 1'b1;
    step();
    check("wr_en_drop", 32'(M_ENABLE), 32'd0);
    M_MISO = 8'h77;
    step();
    check("wr_no_done_busy", 32'(DONE), 32'd0);
    M_BUSY = 1'b0;
    step();
    check("wr_done", 32'(DONE), 32'b0001);
    check("wr_rdata", 32'(RDATA), 32'h77);
    step();
    check("wr_done_pulse", 32'(DONE), 32'd0);

    // Read from requester 2 (pointer now 1)
    REQ_ADDR[20:14] = 7'h50;
    REQ_RW[2]       = 1'b1;
    REQ             = 4'b0100;
    serve(2, 8'h3C, 7'h50);
    REQ = '0;
    check("rd_rw", 32'(M_RW), 32'd1);
    step();
    step();
    check("rd_rdata_hold", 32'(RDATA), 32'h3C);

    // Fairness from a fresh pointer
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      REQ_ADDR[7*i +: 7] = 7'(8'h10 + i);
    end
    REQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(i % NREQ, 8'(8'h80 + i), 7'(8'h10 + (i % NREQ)));
    end
    REQ = '0;

    // Timeout with M_BUSY never rising (pointer now 1)
    REQ = 4'b0010;
    step();
    check("to_ack", 32'(ACK), 32'b0010);
    REQ = '0;
    cnt = 0;
    while (M_ENABLE === 1'b1 && cnt < 50) begin
      cnt++;
      step();
    end
    check("to_en_cycles", 32'(cnt), 32'(TIMEOUT));
    check("to_err", 32'(ERR), 32'b0010);
    check("to_no_done", 32'(DONE), 32'd0);
    step();
    check("to_err_pulse", 32'(ERR), 32'd0);

    // Reset mid-RUN; master stays busy
    REQ = 4'b0001;
    step();
    check("mr_ack", 32'(ACK), 32'b0001);
    M_BUSY = 1'b1;
    step();
    RST = 1'b1;
    step();
    check("mr_rst_en", 32'(M_ENABLE), 32'd0);
    check("mr_rst_addr", 32'(M_ADDR), 32'd0);
    check("mr_rst_gid", 32'(GRANT_ID), 32'd0);
    check("mr_rst_ack", 32'(ACK), 32'd0);
    RST = 1'b0;
    acc = '0;
    repeat (3) begin
      step();
      acc |= ACK;
    end
    check("mr_no_ack_busy", 32'(acc), 32'd0);
    M_BUSY = 1'b0;
    step();
    check("mr_ack_after", 32'(ACK), 32'b0001);
    REQ = '0;
    M_BUSY = 1'b1;
    step();
    M_BUSY = 1'b0;
    step();
    step();

    // Withdrawn request while busy (pointer now 1)
    REQ = 4'b0001;
    step();
    check("wd_ack0", 32'(ACK), 32'b0001);
    REQ = 4'b1000;
    M_BUSY = 1'b1;
    step();
    acc = ACK;
    REQ = '0;
    step();
    acc |= ACK;
    M_BUSY = 1'b0;
    step();
    acc |= ACK;
    check("wd_done", 32'(DONE), 32'b0001);
    step();
    acc |= ACK;
    check("wd_no_ack3", 32'(acc), 32'd0);
    REQ = 4'b1001;
    step();
    check("wd_ptr_ack", 32'(ACK), 32'b1000);
    check("wd_ptr_gid", 32'(GRANT_ID), 32'd3);
    REQ = '0;
    M_BUSY = 1'b1;
    step();
    M_BUSY = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
